sram_1rw_arbiter: RTL

- Shares one single-port 2048x36 read/write SRAM macro between two requesters (port 0, port 1).
- Issues at most one SRAM access per cycle, chosen round-robin.
- The macro registers address, enable and mode internally. Its read data is valid only in the cycle after a read access.
- Buffers read data per port in a small response FIFO, so each requester may stall its response channel independently.
- Sits between the lane datapath clients and the SRAM instance.

---
 rtl/sram_1rw_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/sram_1rw_arbiter.sv
// sram_1rw_arbiter: round-robin sharing of one 1RW SRAM macro between two requesters with per-port response FIFOs
module sram_1rw_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 36,
  parameter int RESP_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic [DATA_WIDTH-1:0] resp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [DATA_WIDTH-1:0] resp1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  output logic                  mem_wmode,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);

  logic [1:0] req_valid, req_write, resp_ready, resp_valid, eligible;
  logic [DATA_WIDTH-1:0] resp_rdata [2];
  logic rr_ptr, rd_pending, rd_port, gnt_any, gnt_port;

  assign req_valid  = {req1_valid, req0_valid};
  assign req_write  = {req1_write, req0_write};
  assign resp_ready = {resp1_ready, resp0_ready};

  // Port 1 wins only when it alone is eligible or when both are and it holds the round-robin turn;
  // with no grant this selects port 0, which is what drives the idle mem_* fields.
  assign gnt_any  = |eligible;
  assign gnt_port = (&eligible) ? rr_ptr : eligible[1];

  assign req0_ready = gnt_any & ~gnt_port;
  assign req1_ready = gnt_any & gnt_port;
  assign mem_en     = gnt_any;
  assign mem_addr   = gnt_port ? req1_addr : req0_addr;
  assign mem_wmode  = gnt_port ? req1_write : req0_write;
  assign mem_wdata  = gnt_port ? req1_wdata : req0_wdata;

  assign resp0_valid = resp_valid[0];
  assign resp1_valid = resp_valid[1];
  assign resp0_rdata = resp_rdata[0];
  assign resp1_rdata = resp_rdata[1];

  // Rotate priority after each grant and remember which port's read data arrives next cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr     <= 1'b0;
      rd_pending <= 1'b0;
      rd_port    <= 1'b0;
    end else begin
      if (gnt_any) rr_ptr <= ~gnt_port;
      rd_pending <= gnt_any & ~mem_wmode;
      rd_port    <= gnt_port;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_port
    logic [DATA_WIDTH-1:0] store [RESP_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic push, pop, has_credit;
    // A read still in the macro pipeline already owns a FIFO slot, so it is charged against credit.
    assign push       = rd_pending & (rd_port == 1'(i));
    assign pop        = (count != '0) & resp_ready[i];
    assign has_credit = (CW+1)'(count) + (CW+1)'(push) < (CW+1)'(RESP_DEPTH);
    assign eligible[i]   = reset_n & req_valid[i] & (req_write[i] | has_credit);
    assign resp_valid[i] = count != '0;
    assign resp_rdata[i] = store[rd_ptr];
    // FIFO occupancy and pointers; contents are dropped on reset.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= (wr_ptr == PW'(RESP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        if (pop) rd_ptr <= (rd_ptr == PW'(RESP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
    // Capture the macro's read data into registered storage so responses never depend on mem_rdata combinationally.
    always_ff @(posedge clock) begin
      if (push) store[wr_ptr] <= mem_rdata;
    end
  end
endmodule
